// File: rtl/dmi_arbiter_if.sv
// DMI arbiter bus bundle: two requester ports plus the single DM-facing port.
// master = requester/DM side driving requests and DM responses,
// slave  = the arbiter itself.
interface dmi_arbiter_if #(
    parameter int DMI_BITS = 40
);
    logic                req0_valid;
    logic [DMI_BITS-1:0] req0_data;
    logic                req0_busy;
    logic                resp0_valid;
    logic [DMI_BITS-1:0] resp0_data;

    logic                req1_valid;
    logic [DMI_BITS-1:0] req1_data;
    logic                req1_busy;
    logic                resp1_valid;
    logic [DMI_BITS-1:0] resp1_data;

    logic                dm_req_valid;
    logic [DMI_BITS-1:0] dm_req_data;
    logic                dm_resp_valid;
    logic [DMI_BITS-1:0] dm_resp_data;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        output dm_resp_valid, dm_resp_data,
        input  req0_busy, resp0_valid, resp0_data,
        input  req1_busy, resp1_valid, resp1_data,
        input  dm_req_valid, dm_req_data
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        input  dm_resp_valid, dm_resp_data,
        output req0_busy, resp0_valid, resp0_data,
        output req1_busy, resp1_valid, resp1_data,
        output dm_req_valid, dm_req_data
    );
endinterface

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: shares the DM's single DMI port between the JTAG DTM (port 0)
// and a secondary debug bridge (port 1). One request is captured per port,
// a round-robin winner is issued to the DM, and the DM response is routed
// back to the issuing port. Only one DM transaction is outstanding at a time.
// Optional feature macro: DMI_TIMEOUT_EN -- aborts a WAIT that exceeds
// TIMEOUT_CYCLES with an op=failed response to the granted port.
module dmi_arbiter #(
    parameter int DMI_ADDR_BITS  = 6,
    parameter int DMI_DATA_BITS  = 32,
    parameter int DMI_OP_BITS    = 2,
    parameter int DMI_BITS       = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic         clk,
    input logic         rst,
    dmi_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

`ifdef DMI_TIMEOUT_EN
    localparam int CNT_LOG = $clog2(TIMEOUT_CYCLES);
    localparam int CNT_W   = (CNT_LOG < 8) ? 8 : ((CNT_LOG > 16) ? 16 : CNT_LOG);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DMI_BITS-1:0] cur_pend;
`endif

    state_t              state_q, state_d;
    logic                busy0_q, busy0_d;
    logic                busy1_q, busy1_d;
    logic [DMI_BITS-1:0] pend0_q, pend0_d;
    logic [DMI_BITS-1:0] pend1_q, pend1_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                dm_req_valid_q, dm_req_valid_d;
    logic [DMI_BITS-1:0] dm_req_data_q, dm_req_data_d;
    logic                resp0_valid_q, resp0_valid_d;
    logic [DMI_BITS-1:0] resp0_data_q, resp0_data_d;
    logic                resp1_valid_q, resp1_valid_d;
    logic [DMI_BITS-1:0] resp1_data_q, resp1_data_d;

    logic                sel;
    logic                resp_fire;
    logic [DMI_BITS-1:0] resp_word;

    // Next-state: per-port capture, arbitration FSM and response routing
    always_comb begin
        state_d        = state_q;
        busy0_d        = busy0_q;
        busy1_d        = busy1_q;
        pend0_d        = pend0_q;
        pend1_d        = pend1_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        dm_req_valid_d = 1'b0;
        dm_req_data_d  = dm_req_data_q;
        resp0_valid_d  = 1'b0;
        resp0_data_d   = resp0_data_q;
        resp1_valid_d  = 1'b0;
        resp1_data_d   = resp1_data_q;
        sel            = 1'b0;
        resp_fire      = 1'b0;
        resp_word      = bus.dm_resp_data;
`ifdef DMI_TIMEOUT_EN
        cnt_d          = cnt_q;
        cur_pend       = grant_q ? pend1_q : pend0_q;
`endif

        // A busy port silently drops further strobes until its response is out.
        if (bus.req0_valid && !busy0_q) begin
            busy0_d = 1'b1;
            pend0_d = bus.req0_data;
        end
        if (bus.req1_valid && !busy1_q) begin
            busy1_d = 1'b1;
            pend1_d = bus.req1_data;
        end

        case (state_q)
            IDLE: begin
                if (busy0_q || busy1_q) begin
                    sel            = (busy0_q && busy1_q) ? ~last_grant_q : busy1_q;
                    grant_d        = sel;
                    dm_req_valid_d = 1'b1;
                    dm_req_data_d  = sel ? pend1_q : pend0_q;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef DMI_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.dm_resp_valid) begin
                    resp_fire = 1'b1;
                    state_d   = RESP;
                end
`ifdef DMI_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    resp_fire = 1'b1;
                    resp_word = {cur_pend[DMI_BITS-1 -: DMI_ADDR_BITS],
                                 {DMI_DATA_BITS{1'b0}}, DMI_OP_BITS'(2)};
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (grant_q) busy1_d = 1'b0;
                else         busy0_d = 1'b0;
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (resp_fire) begin
            if (grant_q) begin
                resp1_valid_d = 1'b1;
                resp1_data_d  = resp_word;
            end else begin
                resp0_valid_d = 1'b1;
                resp0_data_d  = resp_word;
            end
        end
    end

    // State and registered outputs; reset discards anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            busy0_q        <= 1'b0;
            busy1_q        <= 1'b0;
            pend0_q        <= '0;
            pend1_q        <= '0;
            grant_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            dm_req_valid_q <= 1'b0;
            dm_req_data_q  <= '0;
            resp0_valid_q  <= 1'b0;
            resp0_data_q   <= '0;
            resp1_valid_q  <= 1'b0;
            resp1_data_q   <= '0;
`ifdef DMI_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            busy0_q        <= busy0_d;
            busy1_q        <= busy1_d;
            pend0_q        <= pend0_d;
            pend1_q        <= pend1_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            dm_req_valid_q <= dm_req_valid_d;
            dm_req_data_q  <= dm_req_data_d;
            resp0_valid_q  <= resp0_valid_d;
            resp0_data_q   <= resp0_data_d;
            resp1_valid_q  <= resp1_valid_d;
            resp1_data_q   <= resp1_data_d;
`ifdef DMI_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign bus.req0_busy    = busy0_q;
    assign bus.req1_busy    = busy1_q;
    assign bus.dm_req_valid = dm_req_valid_q;
    assign bus.dm_req_data  = dm_req_data_q;
    assign bus.resp0_valid  = resp0_valid_q;
    assign bus.resp0_data   = resp0_data_q;
    assign bus.resp1_valid  = resp1_valid_q;
    assign bus.resp1_data   = resp1_data_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Testbench for dmi_arbiter: directed stimulus pushes expected DM requests and
// per-port responses into queues; a negedge monitor pops and compares whenever
// the DUT strobes dm_req_valid or respN_valid. A small DM model answers each
// request three cycles later with the next word from its answer queue.
module tb_dmi_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmi_arbiter_if #(.DMI_BITS(40)) bus();

    dmi_arbiter #(
        .DMI_ADDR_BITS (6),
        .DMI_DATA_BITS (32),
        .DMI_OP_BITS   (2),
        .DMI_BITS      (40),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] exp_dm[$];
    logic [39:0] exp_r0[$];
    logic [39:0] exp_r1[$];
    logic [39:0] dm_ans[$];

    bit          auto_dm    = 1'b1;
    bit          force_resp = 1'b0;
    logic [39:0] force_data = '0;
    int          dm_delay   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT strobe must match the head of its scoreboard queue
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.dm_req_valid) begin
                if (exp_dm.size() == 0) check("dm_req_unexpected", 64'd1, 64'd0);
                else                    check("dm_req_data", 64'(bus.dm_req_data), 64'(exp_dm.pop_front()));
            end
            if (bus.resp0_valid) begin
                if (exp_r0.size() == 0) check("resp0_unexpected", 64'd1, 64'd0);
                else                    check("resp0_data", 64'(bus.resp0_data), 64'(exp_r0.pop_front()));
            end
            if (bus.resp1_valid) begin
                if (exp_r1.size() == 0) check("resp1_unexpected", 64'd1, 64'd0);
                else                    check("resp1_data", 64'(bus.resp1_data), 64'(exp_r1.pop_front()));
            end
        end
    end

    // DM model: answers 3 cycles after dm_req_valid, or on a forced pulse
    always @(posedge clk) begin
        #1;
        bus.dm_resp_valid = 1'b0;
        if (rst) dm_delay = 0;
        if (dm_delay > 0) begin
            dm_delay--;
            if (dm_delay == 0 && dm_ans.size() > 0) begin
                bus.dm_resp_valid = 1'b1;
                bus.dm_resp_data  = dm_ans.pop_front();
            end
        end
        if (force_resp) begin
            bus.dm_resp_valid = 1'b1;
            bus.dm_resp_data  = force_data;
            force_resp        = 1'b0;
        end
        if (auto_dm && bus.dm_req_valid && !rst) dm_delay = 3;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Caller is at posedge+1; drives a one-cycle strobe on the chosen port(s)
    task automatic pulse(input bit p0, input logic [39:0] d0, input bit p1, input logic [39:0] d1);
        bus.req0_valid = p0; bus.req0_data = d0;
        bus.req1_valid = p1; bus.req1_data = d1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!bus.req0_busy && !bus.req1_busy && exp_r0.size() == 0 && exp_r1.size() == 0) break;
        end
        check({name, "_done"}, 64'(i < 200), 64'd1);
    endtask

    task automatic wait_dm_req(input string name);
        int i;
        for (i = 0; i < 20; i++) begin
            if (bus.dm_req_valid) break;
            @(posedge clk); #1;
        end
        check({name, "_dm_req_seen"}, 64'(i < 20), 64'd1);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_req0_busy"},    64'(bus.req0_busy),    64'd0);
        check({name, "_req1_busy"},    64'(bus.req1_busy),    64'd0);
        check({name, "_dm_req_valid"}, 64'(bus.dm_req_valid), 64'd0);
        check({name, "_resp0_valid"},  64'(bus.resp0_valid),  64'd0);
        check({name, "_resp1_valid"},  64'(bus.resp1_valid),  64'd0);
    endtask

    initial begin
        bus.req0_valid    = 1'b0;
        bus.req0_data     = '0;
        bus.req1_valid    = 1'b0;
        bus.req1_data     = '0;
        bus.dm_resp_valid = 1'b0;
        bus.dm_resp_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_quiet("reset");
        check("reset_dm_req_data", 64'(bus.dm_req_data), 64'd0);
        check("reset_resp0_data",  64'(bus.resp0_data),  64'd0);
        check("reset_resp1_data",  64'(bus.resp1_data),  64'd0);

        // Port 0 read, with capture and issue latency
        exp_dm.push_back({6'h11, 32'h0, 2'b01});
        dm_ans.push_back({6'h11, 32'hA5A5_0001, 2'b00});
        exp_r0.push_back({6'h11, 32'hA5A5_0001, 2'b00});
        pulse(1'b1, {6'h11, 32'h0, 2'b01}, 1'b0, '0);
        check("t1_busy_after_capture", 64'(bus.req0_busy), 64'd1);
        check("t1_dm_req_not_yet",     64'(bus.dm_req_valid), 64'd0);
        @(posedge clk); #1;
        check("t1_dm_req_next_cycle",  64'(bus.dm_req_valid), 64'd1);
        @(posedge clk); #1;
        check("t1_dm_req_one_cycle",   64'(bus.dm_req_valid), 64'd0);
        wait_idle("t1");
        check("t1_busy_cleared", 64'(bus.req0_busy), 64'd0);
        repeat (3) @(posedge clk); #1;
        check("t1_resp0_data_held", 64'(bus.resp0_data), 64'({6'h11, 32'hA5A5_0001, 2'b00}));

        // Both ports in the same cycle after reset: port 0 first
        do_reset();
        exp_dm.push_back({6'h01, 32'h0000_0000, 2'b01});
        exp_dm.push_back({6'h02, 32'h1234_5678, 2'b10});
        dm_ans.push_back({6'h01, 32'hAAAA_0000, 2'b00});
        dm_ans.push_back({6'h02, 32'hBBBB_0000, 2'b00});
        exp_r0.push_back({6'h01, 32'hAAAA_0000, 2'b00});
        exp_r1.push_back({6'h02, 32'hBBBB_0000, 2'b00});
        pulse(1'b1, {6'h01, 32'h0000_0000, 2'b01}, 1'b1, {6'h02, 32'h1234_5678, 2'b10});
        check("t2_both_busy", 64'({bus.req0_busy, bus.req1_busy}), 64'd3);
        wait_idle("t2");

        // Lone port 0 request leaves last_grant=0; the next tie goes to port 1
        exp_dm.push_back({6'h03, 32'h0, 2'b00});
        dm_ans.push_back({6'h03, 32'hCCCC_0003, 2'b00});
        exp_r0.push_back({6'h03, 32'hCCCC_0003, 2'b00});
        pulse(1'b1, {6'h03, 32'h0, 2'b00}, 1'b0, '0);
        wait_idle("t3");
        exp_dm.push_back({6'h05, 32'h0, 2'b01});
        exp_dm.push_back({6'h04, 32'h0, 2'b01});
        dm_ans.push_back({6'h05, 32'hDDDD_0005, 2'b00});
        dm_ans.push_back({6'h04, 32'hEEEE_0004, 2'b00});
        exp_r1.push_back({6'h05, 32'hDDDD_0005, 2'b00});
        exp_r0.push_back({6'h04, 32'hEEEE_0004, 2'b00});
        pulse(1'b1, {6'h04, 32'h0, 2'b01}, 1'b1, {6'h05, 32'h0, 2'b01});
        wait_idle("t4");

        // Port 1 strobes again while busy: second request dropped
        exp_dm.push_back({6'h21, 32'h0000_0042, 2'b10});
        dm_ans.push_back({6'h21, 32'h0000_0000, 2'b00});
        exp_r1.push_back({6'h21, 32'h0000_0000, 2'b00});
        pulse(1'b0, '0, 1'b1, {6'h21, 32'h0000_0042, 2'b10});
        pulse(1'b0, '0, 1'b1, {6'h2F, 32'hDEAD_BEEF, 2'b10});
        check("t5_busy_held", 64'(bus.req1_busy), 64'd1);
        wait_idle("t5");

        // Stray DM response in IDLE: ignored, arbiter still serves normally
        force_data = {6'h3F, 32'hFFFF_FFFF, 2'b11};
        force_resp = 1'b1;
        repeat (4) @(posedge clk); #1;
        check_quiet("t6_stray");
        exp_dm.push_back({6'h10, 32'h0, 2'b00});
        dm_ans.push_back({6'h10, 32'h0000_1010, 2'b00});
        exp_r0.push_back({6'h10, 32'h0000_1010, 2'b00});
        pulse(1'b1, {6'h10, 32'h0, 2'b00}, 1'b0, '0);
        wait_idle("t6");

        // Reset during WAIT, then a late DM response
        auto_dm = 1'b0;
        exp_dm.push_back({6'h12, 32'h0, 2'b01});
        pulse(1'b1, {6'h12, 32'h0, 2'b01}, 1'b0, '0);
        wait_dm_req("t7");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_quiet("t7_in_reset");
        check("t7_resp0_data_cleared", 64'(bus.resp0_data), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        force_data = {6'h12, 32'h5555_5555, 2'b00};
        force_resp = 1'b1;
        repeat (5) @(posedge clk); #1;
        check_quiet("t7_after_late_resp");
        auto_dm = 1'b1;

`ifdef DMI_TIMEOUT_EN
        // Silent DM: failed response 16 WAIT cycles after the ISSUE cycle's successor
        begin
            int cyc;
            auto_dm = 1'b0;
            exp_dm.push_back({6'h22, 32'h0, 2'b01});
            exp_r0.push_back({6'h22, 32'h0, 2'b10});
            pulse(1'b1, {6'h22, 32'h0, 2'b01}, 1'b0, '0);
            wait_dm_req("t8");
            cyc = 0;
            while (!bus.resp0_valid && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("t8_timeout_latency", 64'(cyc), 64'd17);
            wait_idle("t8");
            auto_dm = 1'b1;
        end
`endif

        repeat (4) @(posedge clk); #1;
        check("end_exp_dm_empty", 64'(exp_dm.size()), 64'd0);
        check("end_exp_r0_empty", 64'(exp_r0.size()), 64'd0);
        check("end_exp_r1_empty", 64'(exp_r1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
